// File: rtl/fft4_add_scheduler_if.sv
// rtl/fft4_add_scheduler_if.sv - operand/result bus between the DFT sequencer and its shared FN adder
interface fft4_add_scheduler_if #(
  parameter int FW = 6
);
  logic [FW-1:0] add_a_o;
  logic [FW-1:0] add_b_o;
  logic          add_sub_o;
  logic          add_vld_o;
  logic [FW-1:0] add_res_i;
  logic [4:0]    add_exc_i;

  modport master (
    output add_a_o, add_b_o, add_sub_o, add_vld_o,
    input  add_res_i, add_exc_i
  );

  modport slave (
    input  add_a_o, add_b_o, add_sub_o, add_vld_o,
    output add_res_i, add_exc_i
  );
endinterface

// File: rtl/fft4_add_scheduler.sv
// rtl/fft4_add_scheduler.sv - 4-point DFT sequencer time-sharing one FN add/sub unit
// Optional flag accumulation enabled by defining FFT4_SCHED_EXC_EN.
module fft4_add_scheduler #(
  parameter int FW      = 6,
  parameter int ADD_LAT = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [8*FW-1:0]     x_i,
  output logic [8*FW-1:0]     y_o,
  output logic                busy,
  output logic                done,
  output logic [4:0]          exc_o,
  fft4_add_scheduler_if.master add
);
  typedef enum logic [2:0] {IDLE, S1, DRAIN1, S2, DRAIN2, DONE} state_t;

  localparam logic [2:0] DRAIN_LAST = (ADD_LAT == 0) ? 3'd0 : 3'(ADD_LAT - 1);

  state_t        state, state_nxt;
  logic [2:0]    k;
  logic [2:0]    dcnt;
  logic [FW-1:0] xin [8];
  logic [FW-1:0] s1r [8];
  logic [FW-1:0] xr  [8];

  logic          accept;
  logic          issue;
  logic          stage2;
  logic [2:0]    ia, ib;
  logic          sub_sel;
  logic [FW-1:0] op_a, op_b;

  logic          wb_vld;
  logic          wb_stage2;
  logic [2:0]    wb_k;
  logic [2:0]    wb_xd;
  logic [8*FW-1:0] y_nxt;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign issue  = (state == S1) || (state == S2);
  assign stage2 = (state == S2);
  assign busy   = (state != IDLE) && (state != DONE);
  assign done   = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = S1;
      S1:      if (k == 3'd7) state_nxt = (ADD_LAT == 0) ? S2 : DRAIN1;
      DRAIN1:  if (dcnt == DRAIN_LAST) state_nxt = S2;
      S2:      if (k == 3'd7) state_nxt = (ADD_LAT == 0) ? DONE : DRAIN2;
      DRAIN2:  if (dcnt == DRAIN_LAST) state_nxt = DONE;
      DONE:    state_nxt = start ? S1 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Storage indices: x/s words are {re,im} pairs; s holds a,b,c,d in that order.
  always_comb begin
    ia      = {1'b0, k[2], k[0]};
    ib      = {1'b1, k[2], k[0]};
    sub_sel = k[1];
    if (stage2) begin
      case (k)
        3'd0: begin ia = 3'd0; ib = 3'd4; sub_sel = 1'b0; end
        3'd1: begin ia = 3'd1; ib = 3'd5; sub_sel = 1'b0; end
        3'd2: begin ia = 3'd0; ib = 3'd4; sub_sel = 1'b1; end
        3'd3: begin ia = 3'd1; ib = 3'd5; sub_sel = 1'b1; end
        3'd4: begin ia = 3'd2; ib = 3'd7; sub_sel = 1'b0; end
        3'd5: begin ia = 3'd3; ib = 3'd6; sub_sel = 1'b1; end
        3'd6: begin ia = 3'd2; ib = 3'd7; sub_sel = 1'b1; end
        default: begin ia = 3'd3; ib = 3'd6; sub_sel = 1'b0; end
      endcase
    end
  end

  always_comb begin
    op_a = '0;
    op_b = '0;
    if (issue) begin
      op_a = stage2 ? s1r[ia] : xin[ia];
      op_b = stage2 ? s1r[ib] : xin[ib];
    end
  end

  assign add.add_a_o   = op_a;
  assign add.add_b_o   = op_b;
  assign add.add_sub_o = issue && sub_sel;
  assign add.add_vld_o = issue;

  generate
    if (ADD_LAT == 0) begin : g_wb_comb
      assign wb_vld    = issue;
      assign wb_stage2 = stage2;
      assign wb_k      = k;
    end else begin : g_wb_pipe
      logic [ADD_LAT-1:0] pv;
      logic [ADD_LAT-1:0] ps;
      logic [2:0]         pk [ADD_LAT];

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          pv <= '0;
          ps <= '0;
          for (int i = 0; i < ADD_LAT; i++) pk[i] <= 3'd0;
        end else begin
          pv[0] <= issue;
          ps[0] <= stage2;
          pk[0] <= k;
          for (int i = 1; i < ADD_LAT; i++) begin
            pv[i] <= pv[i-1];
            ps[i] <= ps[i-1];
            pk[i] <= pk[i-1];
          end
        end
      end

      assign wb_vld    = pv[ADD_LAT-1];
      assign wb_stage2 = ps[ADD_LAT-1];
      assign wb_k      = pk[ADD_LAT-1];
    end
  endgenerate

  // Stage-2 op k lands in X slot {k1,k2,k0}: X0,X0,X2,X2,X1,X1,X3,X3.
  assign wb_xd = {wb_k[1], wb_k[2], wb_k[0]};

  // The last writeback shares the edge that enters DONE, so merge it here.
  always_comb begin
    for (int i = 0; i < 8; i++) y_nxt[i*FW +: FW] = xr[i];
    if (wb_vld && wb_stage2) y_nxt[int'(wb_xd)*FW +: FW] = add.add_res_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      k     <= 3'd0;
      dcnt  <= 3'd0;
      y_o   <= '0;
      for (int i = 0; i < 8; i++) begin
        xin[i] <= '0;
        s1r[i] <= '0;
        xr[i]  <= '0;
      end
    end else begin
      state <= state_nxt;
      k     <= issue ? k + 3'd1 : 3'd0;
      dcnt  <= ((state == DRAIN1) || (state == DRAIN2)) ? dcnt + 3'd1 : 3'd0;
      if (accept) begin
        for (int i = 0; i < 8; i++) xin[i] <= x_i[i*FW +: FW];
      end
      if (wb_vld && !wb_stage2) s1r[wb_k] <= add.add_res_i;
      if (wb_vld && wb_stage2)  xr[wb_xd] <= add.add_res_i;
      if (state_nxt == DONE)    y_o <= y_nxt;
    end
  end

`ifdef FFT4_SCHED_EXC_EN
  logic [4:0] acc;
  logic [4:0] acc_nxt;

  assign acc_nxt = acc | (wb_vld ? add.add_exc_i : 5'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc   <= 5'd0;
      exc_o <= 5'd0;
    end else begin
      acc <= accept ? 5'd0 : acc_nxt;
      if (state_nxt == DONE) exc_o <= acc_nxt;
    end
  end
`else
  logic [4:0] exc_unused;
  assign exc_unused = add.add_exc_i;
  assign exc_o      = 5'd0;
`endif
endmodule
